// File: rtl/md_stall_if.sv
// Handshake bundle between the pipeline control and the multiply/divide
// stall controller. The pipeline side is the master and the controller is the slave.
interface md_stall_if;
    logic       start_E;
    logic [1:0] op_E;
    logic       md_use_D;
    logic       other_stall_D;
    logic       kill;
    logic       busy;
    logic       md_done;
    logic [3:0] cnt;
    logic       en_PC;
    logic       en_FD;
    logic       clr_DE;
    logic       proto_err;

    modport master (
        output start_E, op_E, md_use_D, other_stall_D, kill,
        input  busy, md_done, cnt, en_PC, en_FD, clr_DE, proto_err
    );

    modport slave (
        input  start_E, op_E, md_use_D, other_stall_D, kill,
        output busy, md_done, cnt, en_PC, en_FD, clr_DE, proto_err
    );
endinterface

// File: rtl/md_stall_ctrl.sv
// Multiply/divide occupancy tracker and D-stage stall generator.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | MD unit free, cnt = 0
// RUN   | operation in flight, cnt = remaining busy cycles (cnt..1)
module md_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    md_stall_if.slave md
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [0:0] state;
    logic [3:0] cnt_q;
    logic       md_done_q;
    logic       proto_err_q;
    logic       stall;

    // Occupancy state, countdown, completion pulse; kill overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt_q     <= 4'd0;
            md_done_q <= 1'b0;
        end else begin
            md_done_q <= 1'b0;
            if (md.kill) begin
                state <= IDLE;
                cnt_q <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (md.start_E) begin
                            state <= RUN;
                            cnt_q <= md.op_E[1] ? DIV_CNT : MULT_CNT;
                        end
                    end
                    RUN: begin
                        // <= 1 rather than == 1 so cnt can never wrap below zero
                        if (cnt_q <= 4'd1) begin
                            state     <= IDLE;
                            cnt_q     <= 4'd0;
                            md_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Sticky flag: a new issue arrived while the unit was still occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err_q <= 1'b0;
        end else if (md.start_E && (state == RUN)) begin
            proto_err_q <= 1'b1;
        end
    end

    // D-stage stall: MD-class instruction must wait for an issuing or busy unit.
    always_comb begin
        stall = md.other_stall_D | (md.md_use_D & (md.start_E | (state == RUN)));
    end

    assign md.busy      = (state == RUN);
    assign md.cnt       = cnt_q;
    assign md.md_done   = md_done_q;
    assign md.proto_err = proto_err_q;
    assign md.en_PC     = ~stall;
    assign md.en_FD     = ~stall;
    assign md.clr_DE    = stall;
endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: directed scenarios then random traffic,
// compared against a schedule-based reference model.
module tb_md_stall_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk;
    logic reset;
    md_stall_if mif();

    md_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    // clk starts high so the first half period lands on a falling edge
    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: an accepted op is remembered as (issue edge, latency);
    // every expected output is derived from the distance to that edge.
    int cyc      = 0;
    int acc_edge = -1;
    int acc_lat  = 0;
    bit m_proto  = 1'b0;

    function automatic bit m_busy(int c);
        return (acc_edge >= 0) && (c > acc_edge) && (c <= acc_edge + acc_lat);
    endfunction

    function automatic int m_cnt(int c);
        return m_busy(c) ? (acc_edge + acc_lat + 1 - c) : 0;
    endfunction

    function automatic bit m_done(int c);
        return (acc_edge >= 0) && (c == acc_edge + acc_lat + 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        bit st;
        st = mif.other_stall_D | (mif.md_use_D & (mif.start_E | m_busy(cyc)));
        chk("busy",      int'(mif.busy),      int'(m_busy(cyc)));
        chk("cnt",       int'(mif.cnt),       m_cnt(cyc));
        chk("md_done",   int'(mif.md_done),   int'(m_done(cyc)));
        chk("en_PC",     int'(mif.en_PC),     int'(!st));
        chk("en_FD",     int'(mif.en_FD),     int'(!st));
        chk("clr_DE",    int'(mif.clr_DE),    int'(st));
        chk("proto_err", int'(mif.proto_err), int'(m_proto));
    endtask

    task automatic model_edge();
        bit b;
        b = m_busy(cyc);
        if (mif.start_E && b) m_proto = 1'b1;
        if (mif.kill) acc_edge = -1;
        else if (mif.start_E && !b) begin
            acc_edge = cyc;
            acc_lat  = mif.op_E[1] ? DIV_LAT : MULT_LAT;
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model at the edge.
    task automatic step(input bit s, input logic [1:0] op, input bit use_d,
                        input bit oth, input bit k);
        mif.start_E       = s;
        mif.op_E          = op;
        mif.md_use_D      = use_d;
        mif.other_stall_D = oth;
        mif.kill          = k;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse launched between edges.
    task automatic async_reset(input int hold);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy",    int'(mif.busy),      0);
        chk("rst_cnt",     int'(mif.cnt),       0);
        chk("rst_md_done", int'(mif.md_done),   0);
        chk("rst_proto",   int'(mif.proto_err), 0);
        acc_edge = -1;
        m_proto  = 1'b0;
        mif.start_E = 1'b0;
        mif.kill    = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset             = 1'b0;
        mif.start_E       = 1'b0;
        mif.op_E          = 2'b00;
        mif.md_use_D      = 1'b1;
        mif.other_stall_D = 1'b0;
        mif.kill          = 1'b0;
        #1;
        chk("reset_busy",    int'(mif.busy),      0);
        chk("reset_cnt",     int'(mif.cnt),       0);
        chk("reset_done",    int'(mif.md_done),   0);
        chk("reset_proto",   int'(mif.proto_err), 0);
        chk("reset_en_PC",   int'(mif.en_PC),     1);
        chk("reset_clr_DE",  int'(mif.clr_DE),    0);
        mif.md_use_D = 1'b0;
        #1 reset = 1'b1;

        // mult accepted at the very first edge after release
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(7);

        // div with mflo held in D: stalled through the busy window
        step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle(1);

        // kill in cycle 3 of a div; no completion afterwards
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(12);

        // kill and start together from IDLE: kill wins
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(3);

        // back-to-back: second mult issued in the md_done cycle
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        idle(7);

        // other_stall alone
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);

        // start while busy: ignored, proto_err sticks
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        idle(6);

        // async reset in cycle 4 of a div, clears proto_err as well
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        idle(3);
        async_reset(2);
        idle(12);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset($urandom_range(0, 2));
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
